// File: rtl/led_bar_pkg.sv
// Shared definitions for the LED bar arbiter: sizes, FSM state type,
// the PMOD pin to leds-bit wiring table and the round-robin pick helper.
package led_bar_pkg;

  localparam int NUM_REQ   = 4;
  localparam int LED_W     = 8;
  localparam int REQ_IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Entry n gives the leds bit that drives pin PMOD(n+1); the bar is wired
  // with odd pins carrying the upper nibble and even pins the lower nibble.
  localparam logic [2:0] PMOD_LED_IDX [LED_W] = '{3'd4, 3'd0, 3'd5, 3'd1,
                                                  3'd6, 3'd2, 3'd7, 3'd3};

  // Active-low pin vector, bit n = PMOD(n+1).
  function automatic logic [LED_W-1:0] pmod_drive(input logic [LED_W-1:0] leds);
    pmod_drive = '1;
    for (int n = 0; n < LED_W; n++) begin
      pmod_drive[n] = ~leds[PMOD_LED_IDX[n]];
    end
  endfunction

  // First asserted request scanning upward from last+1, wrapping modulo NUM_REQ.
  // last itself is considered only after every other requester.
  function automatic logic [REQ_IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0]   req,
                                                   input logic [REQ_IDX_W-1:0] last);
    logic [REQ_IDX_W-1:0] idx;
    logic                 found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + REQ_IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running prescaler: tick pulses for one cycle every 2^PRESCALE_W cycles,
// on the cycle the counter sits at all-ones. The raw count is exported for
// the optional heartbeat blink.
module led_tick_prescaler #(
  parameter int PRESCALE_W = 20
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  output logic                  tick,
  output logic [PRESCALE_W-1:0] count
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;

  // Next count simply wraps through all-ones back to zero.
  always_comb begin
    count_d = count_q + PRESCALE_W'(1);
  end

  // Counter register, cleared by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick  = &count_q;
  assign count = count_q;

endmodule

// File: rtl/led_bar_arbiter.sv
// Round-robin arbiter handing a shared 8-LED bar to one of four requesters.
// The owner keeps the bar until it drops its request, or until it has held
// it for DWELL_TICKS prescaler ticks while someone else is waiting. One dark
// IDLE cycle always separates consecutive grants.
//
// Build option: define LED_BAR_ARBITER_HEARTBEAT_EN to make the status LED a
// free-running blink from the prescaler MSB instead of a "bar owned" light.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no grant, bar dark; any request is granted on the next edge
// OWN   | one requester granted, its pattern mirrored onto the bar
module led_bar_arbiter
  import led_bar_pkg::*;
#(
  parameter int PRESCALE_W  = 20,
  parameter int DWELL_TICKS = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*LED_W-1:0] PAT,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [REQ_IDX_W-1:0]     OWNER,
  output logic                     LED,
  output logic                     PMOD1,
  output logic                     PMOD2,
  output logic                     PMOD3,
  output logic                     PMOD4,
  output logic                     PMOD5,
  output logic                     PMOD6,
  output logic                     PMOD7,
  output logic                     PMOD8
);

  localparam logic [7:0] DWELL_MAX = 8'(DWELL_TICKS);

  logic                  tick;
  logic [PRESCALE_W-1:0] prescale_count;

  led_tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .CLK  (CLK),
    .RST_N(RST_N),
    .tick (tick),
    .count(prescale_count)
  );

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [REQ_IDX_W-1:0] owner_q, owner_d;
  logic [LED_W-1:0]     leds_q, leds_d;
  logic [7:0]           dwell_q, dwell_d;

  logic [REQ_IDX_W-1:0] winner;
  logic                 owner_req;
  logic                 other_req;
  logic                 dwell_full;

  // Next-state and next-output decisions for the arbiter.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    leds_d     = leds_q;
    dwell_d    = dwell_q;
    winner     = rr_pick(REQ, owner_q);
    owner_req  = REQ[owner_q];
    other_req  = |(REQ & ~gnt_q);
    dwell_full = (dwell_q == DWELL_MAX);

    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        leds_d = '0;
        if (|REQ) begin
          state_d = OWN;
          gnt_d   = NUM_REQ'(1) << winner;
          owner_d = winner;
          dwell_d = '0;
        end
      end
      OWN: begin
        // Release wins over preemption, though both land in IDLE anyway.
        if (!owner_req || (dwell_full && other_req)) begin
          state_d = IDLE;
          gnt_d   = '0;
          leds_d  = '0;
        end else begin
          leds_d = PAT[{owner_q, 3'b000} +: LED_W];
          if (tick && !dwell_full) begin
            dwell_d = dwell_q + 8'd1;
          end
        end
      end
    endcase
  end

  // Arbiter state and registered outputs; OWNER resets to 3 so requester 0
  // is the first round-robin candidate.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '1;
      leds_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      leds_q  <= leds_d;
      dwell_q <= dwell_d;
    end
  end

  logic [LED_W-1:0] pmod_n;

  assign pmod_n = pmod_drive(leds_q);
  assign PMOD1  = pmod_n[0];
  assign PMOD2  = pmod_n[1];
  assign PMOD3  = pmod_n[2];
  assign PMOD4  = pmod_n[3];
  assign PMOD5  = pmod_n[4];
  assign PMOD6  = pmod_n[5];
  assign PMOD7  = pmod_n[6];
  assign PMOD8  = pmod_n[7];

  assign GNT   = gnt_q;
  assign OWNER = owner_q;

`ifdef LED_BAR_ARBITER_HEARTBEAT_EN
  assign LED = ~prescale_count[PRESCALE_W-1];
`else
  logic unused_prescale_count;
  assign unused_prescale_count = ^prescale_count;
  assign LED = ~(|gnt_q);
`endif

endmodule

// File: tb/tb_led_bar_arbiter.sv
// Bench for led_bar_arbiter with a short prescaler and dwell: directed
// vector table, hand-written multi-cycle sequences and a random soak, all
// against a behavioural reference model.
module tb_led_bar_arbiter;

  localparam int TB_PW      = 4;
  localparam int TB_DW      = 3;
  localparam int OWN_CYCLES = TB_DW << TB_PW;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [31:0] PAT;
  logic [3:0]  GNT;
  logic [1:0]  OWNER;
  logic        LED;
  logic        PMOD1, PMOD2, PMOD3, PMOD4, PMOD5, PMOD6, PMOD7, PMOD8;
  logic [7:0]  pm;

  assign pm = {PMOD8, PMOD7, PMOD6, PMOD5, PMOD4, PMOD3, PMOD2, PMOD1};

  led_bar_arbiter #(
    .PRESCALE_W (TB_PW),
    .DWELL_TICKS(TB_DW)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .REQ  (REQ),
    .PAT  (PAT),
    .GNT  (GNT),
    .OWNER(OWNER),
    .LED  (LED),
    .PMOD1(PMOD1),
    .PMOD2(PMOD2),
    .PMOD3(PMOD3),
    .PMOD4(PMOD4),
    .PMOD5(PMOD5),
    .PMOD6(PMOD6),
    .PMOD7(PMOD7),
    .PMOD8(PMOD8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pin vector {PMOD8..PMOD1} expected for a leds value, straight from the wiring list.
  function automatic logic [7:0] pmod_of(input logic [7:0] l);
    logic [7:0] p;
    p[6] = !l[7];
    p[4] = !l[6];
    p[2] = !l[5];
    p[0] = !l[4];
    p[7] = !l[3];
    p[5] = !l[2];
    p[3] = !l[1];
    p[1] = !l[0];
    return p;
  endfunction

  // ---------------- reference model ----------------
  bit         m_own;
  logic [3:0] m_gnt;
  int         m_owner;
  logic [7:0] m_leds;
  int         m_dwell;
  int         m_pre;
  bit         m_tick;
  bit         m_found;
  int         m_win;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_own   = 0;
      m_gnt   = 4'b0000;
      m_owner = 3;
      m_leds  = 8'h00;
      m_dwell = 0;
      m_pre   = 0;
    end else begin
      m_tick = (m_pre == (1 << TB_PW) - 1);
      m_pre  = (m_pre + 1) % (1 << TB_PW);
      if (!m_own) begin
        m_leds = 8'h00;
        if (REQ != 4'b0000) begin
          m_found = 0;
          m_win   = 0;
          for (int k = 1; k <= 4; k++) begin
            if (!m_found && REQ[(m_owner + k) % 4]) begin
              m_found = 1;
              m_win   = (m_owner + k) % 4;
            end
          end
          m_own   = 1;
          m_owner = m_win;
          m_gnt   = 4'b0001 << m_win;
          m_dwell = 0;
        end
      end else begin
        if (!REQ[m_owner] ||
            (m_dwell == TB_DW && (REQ & ~(4'b0001 << m_owner)) != 4'b0000)) begin
          m_own  = 0;
          m_gnt  = 4'b0000;
          m_leds = 8'h00;
        end else begin
          m_leds = PAT[8*m_owner +: 8];
          if (m_tick && m_dwell < TB_DW) m_dwell = m_dwell + 1;
        end
      end
    end
  end

  task automatic cmp_model();
    logic onehot_ok;
    check("model_gnt", 32'(GNT), 32'(m_gnt));
    check("model_owner", 32'(OWNER), 32'(m_owner));
    check("model_pmod", 32'(pm), 32'(pmod_of(m_leds)));
`ifdef LED_BAR_ARBITER_HEARTBEAT_EN
    check("model_led", 32'(LED), 32'(((m_pre >> (TB_PW - 1)) & 1) == 0));
`else
    check("model_led", 32'(LED), 32'(m_gnt == 4'b0000));
`endif
    onehot_ok = (GNT == 4'b0000) || (GNT == (4'b0001 << OWNER));
    check("gnt_onehot", 32'(onehot_ok), 32'd1);
  endtask

  task automatic cyc();
    @(negedge CLK);
    cmp_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  req;
    logic [31:0] pat;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  leds;
  } vec_t;

  vec_t vt [11];

  int   n_own;
  bit   hold_ok;
  bit   prev_led;
  int   run_len;
  int   toggles;

  initial begin
    vt[0]  = '{4'b0000, 32'h0000_0000, 4'b0000, 2'd3, 8'h00};
    vt[1]  = '{4'b0010, 32'h0000_8100, 4'b0010, 2'd1, 8'h00};
    vt[2]  = '{4'b0010, 32'h0000_8100, 4'b0010, 2'd1, 8'h81};
    vt[3]  = '{4'b0010, 32'h0000_3C00, 4'b0010, 2'd1, 8'h3C};
    vt[4]  = '{4'b0000, 32'h0000_3C00, 4'b0000, 2'd1, 8'h00};
    vt[5]  = '{4'b0100, 32'h0055_0000, 4'b0100, 2'd2, 8'h00};
    vt[6]  = '{4'b0100, 32'h0055_0000, 4'b0100, 2'd2, 8'h55};
    vt[7]  = '{4'b0101, 32'h0055_0000, 4'b0100, 2'd2, 8'h55};
    vt[8]  = '{4'b0001, 32'h0055_0000, 4'b0000, 2'd2, 8'h00};
    vt[9]  = '{4'b0001, 32'h0000_00A5, 4'b0001, 2'd0, 8'h00};
    vt[10] = '{4'b0000, 32'h0000_00A5, 4'b0000, 2'd0, 8'h00};

    RST_N = 1'b0;
    REQ   = 4'b0000;
    PAT   = 32'h0;
    repeat (3) cyc();
    check("rst_gnt", 32'(GNT), 32'd0);
    check("rst_owner", 32'(OWNER), 32'd3);
    check("rst_pmod", 32'(pm), 32'hFF);
    check("rst_led", 32'(LED), 32'd1);
    RST_N = 1'b1;

    for (int i = 0; i < 11; i++) begin
      REQ = vt[i].req;
      PAT = vt[i].pat;
      cyc();
      check($sformatf("tbl%0d_gnt", i), 32'(GNT), 32'(vt[i].gnt));
      check($sformatf("tbl%0d_owner", i), 32'(OWNER), 32'(vt[i].owner));
      check($sformatf("tbl%0d_pmod", i), 32'(pm), 32'(pmod_of(vt[i].leds)));
`ifndef LED_BAR_ARBITER_HEARTBEAT_EN
      check($sformatf("tbl%0d_led", i), 32'(LED), 32'(vt[i].gnt == 4'b0000));
`endif
      if (i == 2) check("single_pmod_81", 32'(pm), 32'hBD);
    end

    // Reset in the middle of an ownership drops everything before any edge.
    REQ = 4'b0100;
    cyc();
    cyc();
    check("pre_rst_gnt", 32'(GNT), 32'b0100);
    #2 RST_N = 1'b0;
    #1;
    check("midrst_gnt", 32'(GNT), 32'd0);
    check("midrst_pmod", 32'(pm), 32'hFF);
    check("midrst_owner", 32'(OWNER), 32'd3);
    check("midrst_led", 32'(LED), 32'd1);
    cyc();

    // Preemption: requester 0 keeps the bar for exactly DWELL ticks.
    REQ   = 4'b0011;
    RST_N = 1'b1;
    n_own = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (GNT == 4'b0001) n_own++;
      else if (n_own > 0) break;
    end
    check("preempt_own_cycles", 32'(n_own), 32'(OWN_CYCLES));
    check("preempt_idle_gap", 32'(GNT), 32'd0);
    cyc();
    check("preempt_next_gnt", 32'(GNT), 32'b0010);
    check("preempt_next_owner", 32'(OWNER), 32'd1);

    // Release at dwell 1 by owner 3 with requester 0 waiting, wrapping to 0.
    REQ = 4'b1000;
    cyc();
    check("rel_idle", 32'(GNT), 32'd0);
    cyc();
    check("own3_gnt", 32'(GNT), 32'b1000);
    REQ     = 4'b1001;
    hold_ok = 1;
    for (int i = 0; i < (1 << TB_PW); i++) begin
      cyc();
      if (GNT != 4'b1000) hold_ok = 0;
    end
    check("own3_hold_dwell1", 32'(hold_ok), 32'd1);
    REQ = 4'b0001;
    cyc();
    check("wrap_idle", 32'(GNT), 32'd0);
    check("wrap_idle_pmod", 32'(pm), 32'hFF);
    cyc();
    check("wrap_gnt", 32'(GNT), 32'b0001);
    check("wrap_owner", 32'(OWNER), 32'd0);

    // Live pattern change while requester 2 owns the bar.
    REQ = 4'b0100;
    PAT = 32'h0001_0000;
    cyc();
    cyc();
    check("own2_gnt", 32'(GNT), 32'b0100);
    cyc();
    check("pat01_pmod2", 32'(PMOD2), 32'd0);
    check("pat01_pmod7", 32'(PMOD7), 32'd1);
    PAT = 32'h0080_0000;
    #1;
    check("pat_nochange_pmod2", 32'(PMOD2), 32'd0);
    cyc();
    check("pat80_pmod2", 32'(PMOD2), 32'd1);
    check("pat80_pmod7", 32'(PMOD7), 32'd0);

    // A lone requester keeps ownership well past the dwell limit.
    hold_ok = 1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (GNT != 4'b0100) hold_ok = 0;
    end
    check("lone_hold", 32'(hold_ok), 32'd1);

`ifdef LED_BAR_ARBITER_HEARTBEAT_EN
    prev_led = LED;
    run_len  = 0;
    toggles  = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (LED == prev_led) begin
        run_len++;
      end else begin
        toggles++;
        if (toggles > 1) check("hb_half_period", 32'(run_len), 32'd8);
        run_len  = 1;
        prev_led = LED;
      end
    end
    check("hb_toggled", 32'(toggles >= 6), 32'd1);
`else
    REQ = 4'b0000;
    cyc();
    check("led_off_idle", 32'(LED), 32'd1);
    REQ = 4'b1000;
    cyc();
    check("led_on_own", 32'(LED), 32'd0);
`endif

    // Random soak against the reference model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) REQ = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) PAT = $urandom;
      RST_N = ($urandom_range(0, 599) != 0);
      cyc();
    end
    RST_N = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_bar_arbiter.md
LED_BAR_ARBITER -- requirements
Module: led_bar_arbiter

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 20, giving tick period = 2^PRESCALE_W CLK cycles.
REQ-002 SHALL have parameter DWELL_TICKS, default 8, giving the minimum ownership in ticks before preemption; range 1..255.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port REQ, input, 4 bits: per-requester request, level-sensitive.
REQ-006 SHALL have port PAT, input, 32 bits: requester i's LED pattern on PAT[8i+7:8i], bit set = LED on.
REQ-007 SHALL have port GNT, output, 4 bits: one-hot grant, or all zero when idle.
REQ-008 SHALL have port OWNER, output, 2 bits: index of the current or last owner.
REQ-009 SHALL have port LED, output, 1 bit: status LED, active-low.
REQ-010 SHALL have ports PMOD1..PMOD8, output, 1 bit each: active-low LED bar drive.

Function
REQ-011 SHALL hold an internal 8-bit register leds and drive it as follows: PMOD7=!leds[7], PMOD5=!leds[6], PMOD3=!leds[5], PMOD1=!leds[4], PMOD8=!leds[3], PMOD6=!leds[2], PMOD4=!leds[1], PMOD2=!leds[0].
REQ-012 SHALL implement the prescaler as follows: a free-running PRESCALE_W-bit counter; tick is a one-cycle pulse when the counter equals all-ones.
REQ-013 SHALL use a two-state FSM, IDLE and OWN.
REQ-014 SHALL, in IDLE with REQ!=0, move to OWN on the next edge; GNT takes the round-robin winner, OWNER takes the winner index, and dwell is set to 0.
REQ-015 SHALL pick the round-robin winner as the first asserted REQ bit scanning from OWNER+1 upward, modulo 4.
REQ-016 SHALL, in IDLE with REQ==0, keep GNT=0 and leds=0.
REQ-017 SHALL, in OWN, load leds with PAT[owner] every cycle, so a pattern change appears on the PMOD pins one cycle later.
REQ-018 SHALL, in OWN, increment the 8-bit dwell counter on each tick, saturating at DWELL_TICKS.
REQ-019 SHALL, in OWN, treat the owner's REQ deasserting as release: next edge goes to IDLE, GNT=0 and leds=0, regardless of dwell.
REQ-020 SHALL, in OWN, treat dwell==DWELL_TICKS with any other REQ bit set as preemption: next edge goes to IDLE, GNT=0 and leds=0.
REQ-021 SHALL keep the owner in OWN indefinitely when dwell==DWELL_TICKS and no other REQ bit is set.
REQ-022 SHALL resolve release and preemption on the same cycle as release; both result in IDLE.
REQ-023 SHALL insert exactly one IDLE cycle, with bar dark, between any two consecutive grants.
REQ-024 SHALL keep GNT one-hot or zero at all times, with OWNER equal to the index of the GNT bit whenever GNT!=0.

Reset
REQ-025 SHALL, while RST_N=0, asynchronously force: FSM=IDLE, GNT=0, OWNER=3 (so requester 0 wins first), leds=0, all PMODn=1, dwell=0, prescaler=0, LED=1.
REQ-026 SHALL, on reset assertion mid-OWN, drop the grant immediately without waiting for a clock edge.

Configuration
REQ-027 SHALL, with macro LED_BAR_ARBITER_HEARTBEAT_EN defined, drive LED = !prescaler[PRESCALE_W-1], a free-running blink.
REQ-028 SHALL, without LED_BAR_ARBITER_HEARTBEAT_EN, drive LED = !(GNT!=0), lit while any requester owns the bar.

Structure
REQ-029 SHALL take its shared definitions from package led_bar_pkg: NUM_REQ=4, LED_W=8, the FSM state enum (IDLE, OWN), and the PMOD bit-to-leds index mapping table.
REQ-030 SHALL instantiate sub-module led_tick_prescaler (parameter PRESCALE_W; ports CLK, RST_N, tick, count) for the prescaler; the FSM and arbitration stay in led_bar_arbiter.

Verification
Bench uses PRESCALE_W=4 and DWELL_TICKS=3.
REQ-031 SHALL cover reset: RST_N=0 then released, with REQ=0 -> GNT=0, OWNER=3, all PMODn=1; assert RST_N=0 mid-OWN -> GNT=0 and PMODs=1 before the next edge.
REQ-032 SHALL cover a single requester: REQ=0010, PAT[15:8]=8'h81 -> GNT=0010 one edge later, then PMOD7=0, PMOD2=0 and other PMODs=1 one edge after that; ownership held past 3 ticks.
REQ-033 SHALL cover preemption: REQ=0011 from IDLE at reset -> requester 0 owns for exactly 3 ticks, one IDLE cycle, then GNT=0010.
REQ-034 SHALL cover release and wrap-around: owner 3 drops REQ[3] at dwell 1 while REQ=1001 -> IDLE next cycle, then GNT=0001.
REQ-035 SHALL cover a live pattern change: while owner 2, PAT[23:16] steps 8'h01 to 8'h80 -> PMOD2 rises and PMOD7 falls exactly one cycle after the change.
REQ-036 SHALL cover both macro builds: LED toggles every 8 cycles with LED_BAR_ARBITER_HEARTBEAT_EN; without it, LED=0 exactly while GNT!=0.
